// File: rtl/ivl_uvm_ovl_pkg.sv
// Shared types and helpers for the ivl_uvm_ovl window checkers.
// Also supplies the OVL severity/property/coverage constants when the
// standard OVL defines file has not been pulled in ahead of this file.

`ifndef OVL_FATAL
`define OVL_FATAL 0
`endif
`ifndef OVL_ERROR
`define OVL_ERROR 1
`endif
`ifndef OVL_WARNING
`define OVL_WARNING 2
`endif
`ifndef OVL_INFO
`define OVL_INFO 3
`endif
`ifndef OVL_ASSERT
`define OVL_ASSERT 0
`endif
`ifndef OVL_ASSUME
`define OVL_ASSUME 1
`endif
`ifndef OVL_COVER_NONE
`define OVL_COVER_NONE 0
`endif
`ifndef OVL_COVER_ALL
`define OVL_COVER_ALL 15
`endif

package ivl_uvm_ovl_pkg;

  // Per-channel window state.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ovl_win_state_e;

  // Why the most recent violation fired.
  typedef enum logic [1:0] {
    NONE    = 2'd0,
    EARLY   = 2'd1,
    TIMEOUT = 2'd2
  } ovl_win_reason_e;

  // Saturating add: a + b clamped to maxVal. One extra bit keeps the raw
  // sum from wrapping before the clamp is applied.
  function automatic logic [31:0] ovl_sat_add(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] maxVal);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, maxVal}) begin
      return maxVal;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/ivl_uvm_ovl_window_ch.sv
// One channel of the window checker: IDLE/WAIT FSM, window counter and
// the fire registers. A decision taken on edge E is held in a pending
// register and presented on the fire outputs from edge E+1 for one cycle.
// Optional X/Z detection is built when IVL_UVM_OVL_XCHECK_EN is defined.

module ivl_uvm_ovl_window_ch
  import ivl_uvm_ovl_pkg::*;
#(
  parameter int    SEVERITY_LEVEL = `OVL_ERROR,
  parameter int    PROPERTY_TYPE  = `OVL_ASSERT,
  parameter string MSG            = "ovl_window_multi violation",
  parameter bit    COVER_EN       = 1'b1,
  parameter int    MIN_CKS        = 1,
  parameter int    MAX_CKS        = 8,
  parameter int    CH_IDX         = 0,
  parameter int    CNT_W          = $clog2(MAX_CKS + 1)
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_start,
  input  logic i_test,
  output logic o_fire_err,
  output logic o_fire_cov,
  output logic o_fire_x,
  output logic o_busy,
  output logic o_err_next
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_CKS);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CKS);

  ovl_win_state_e  r_state;
  ovl_win_reason_e r_reason;
  logic [CNT_W-1:0] r_cnt;
  logic r_pend_err;
  logic r_pend_cov;
  logic r_pend_x;
  logic r_fire_err;
  logic r_fire_cov;
  logic r_fire_x;
  logic r_busy;

`ifdef IVL_UVM_OVL_XCHECK_EN
  logic w_x_bad;
  // test_expr only matters while a window is open, so X on it in IDLE is harmless.
  assign w_x_bad = $isunknown(i_start) ||
                   ((r_state == WAIT) && $isunknown(i_test));
`endif

  // Channel FSM: open on start, then early / pass / timeout decision per edge.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_reason   <= NONE;
      r_cnt      <= '0;
      r_pend_err <= 1'b0;
      r_pend_cov <= 1'b0;
      r_pend_x   <= 1'b0;
      r_fire_err <= 1'b0;
      r_fire_cov <= 1'b0;
      r_fire_x   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_fire_err <= r_pend_err;
      r_fire_cov <= r_pend_cov & COVER_EN;
      r_fire_x   <= r_pend_x;
      r_pend_err <= 1'b0;
      r_pend_cov <= 1'b0;
      r_pend_x   <= 1'b0;
      if (!i_enable) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
`ifdef IVL_UVM_OVL_XCHECK_EN
      end else if (w_x_bad) begin
        r_state  <= IDLE;
        r_cnt    <= '0;
        r_busy   <= 1'b0;
        r_pend_x <= 1'b1;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start) begin
              r_state <= WAIT;
              r_cnt   <= CNT_W'(1);
              r_busy  <= 1'b1;
            end
          end
          WAIT: begin
            if (i_test) begin
              r_state <= IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              if (r_cnt < MIN_C) begin
                r_pend_err <= 1'b1;
                r_reason   <= EARLY;
              end else begin
                r_pend_cov <= 1'b1;
              end
            end else if (r_cnt >= MAX_C) begin
              r_state    <= IDLE;
              r_cnt      <= '0;
              r_busy     <= 1'b0;
              r_pend_err <= 1'b1;
              r_reason   <= TIMEOUT;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  // Report each violation in the cycle its fire pulse is presented.
  always @(posedge i_clock) begin
    if (i_reset && r_pend_err) begin
      if (PROPERTY_TYPE == `OVL_ASSUME) begin
        $display("ASSUME %s ch%0d %s sev%0d", MSG, CH_IDX, r_reason.name(), SEVERITY_LEVEL);
      end else begin
        $display("%s ch%0d %s sev%0d", MSG, CH_IDX, r_reason.name(), SEVERITY_LEVEL);
      end
    end
  end
`endif

  assign o_fire_err = r_fire_err;
  assign o_fire_cov = r_fire_cov;
  assign o_fire_x   = r_fire_x;
  assign o_busy     = r_busy;
  assign o_err_next = r_pend_err;

endmodule

// File: rtl/ivl_uvm_ovl_window_multi.sv
// Multi-channel window checker top: NUM_CH independent channels plus a
// saturating violation counter that adds every channel's upcoming
// fire_err in the same edge the pulse appears.
// Optional X/Z detection: define IVL_UVM_OVL_XCHECK_EN.

module ivl_uvm_ovl_window_multi
  import ivl_uvm_ovl_pkg::*;
#(
  parameter int    SEVERITY_LEVEL = `OVL_ERROR,
  parameter int    PROPERTY_TYPE  = `OVL_ASSERT,
  parameter string MSG            = "ovl_window_multi violation",
  parameter int    COVERAGE_LEVEL = `OVL_COVER_ALL,
  parameter int    NUM_CH         = 4,
  parameter int    MIN_CKS        = 1,
  parameter int    MAX_CKS        = 8,
  parameter int    ERR_W          = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] start_event,
  input  logic [NUM_CH-1:0] test_expr,
  output logic [NUM_CH-1:0] fire_err,
  output logic [NUM_CH-1:0] fire_cov,
  output logic [NUM_CH-1:0] fire_x,
  output logic [ERR_W-1:0]  err_count,
  output logic [NUM_CH-1:0] busy
);

  localparam int          CNT_W    = $clog2(MAX_CKS + 1);
  localparam bit          COVER_EN = (COVERAGE_LEVEL != `OVL_COVER_NONE);
  localparam logic [31:0] ERR_MAX  = 32'((64'd1 << ERR_W) - 64'd1);

  logic [NUM_CH-1:0] w_err_next;
  logic [31:0]       w_err_pop;
  logic [ERR_W-1:0]  r_err_count;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ivl_uvm_ovl_window_ch #(
      .SEVERITY_LEVEL (SEVERITY_LEVEL),
      .PROPERTY_TYPE  (PROPERTY_TYPE),
      .MSG            (MSG),
      .COVER_EN       (COVER_EN),
      .MIN_CKS        (MIN_CKS),
      .MAX_CKS        (MAX_CKS),
      .CH_IDX         (g),
      .CNT_W          (CNT_W)
    ) u_ch (
      .i_clock    (clock),
      .i_reset    (reset),
      .i_enable   (enable),
      .i_start    (start_event[g]),
      .i_test     (test_expr[g]),
      .o_fire_err (fire_err[g]),
      .o_fire_cov (fire_cov[g]),
      .o_fire_x   (fire_x[g]),
      .o_busy     (busy[g]),
      .o_err_next (w_err_next[g])
    );
  end

  // Count how many channels will pulse fire_err on the coming edge.
  always_comb begin
    w_err_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_err_pop = w_err_pop + 32'(w_err_next[i]);
    end
  end

  // Accumulate violations, holding at the top of the counter range.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err_count <= '0;
    end else begin
      r_err_count <= ERR_W'(ovl_sat_add(32'(r_err_count), w_err_pop, ERR_MAX));
    end
  end

  assign err_count = r_err_count;

endmodule

// File: tb/tb_ivl_uvm_ovl_window_multi.sv
// Directed bench for ivl_uvm_ovl_window_multi (NUM_CH=4, MIN_CKS=2,
// MAX_CKS=5) plus a single-channel ERR_W=2 instance for saturation.

module tb_ivl_uvm_ovl_window_multi;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] startEvent;
  logic [3:0] testExpr;
  logic [3:0] fireErr;
  logic [3:0] fireCov;
  logic [3:0] fireX;
  logic [7:0] errCount;
  logic [3:0] busy;

  logic [0:0] satStart;
  logic [0:0] satTest;
  logic [0:0] satFireErr;
  logic [0:0] satFireCov;
  logic [0:0] satFireX;
  logic [1:0] satErrCount;
  logic [0:0] satBusy;

  int checkCount;
  int errorCount;

  typedef struct {
    logic       en;
    logic [3:0] start;
    logic [3:0] test;
    logic [3:0] expErr;
    logic [3:0] expCov;
    logic [3:0] expBusy;
    logic [7:0] expCnt;
  } vec_t;

  vec_t vecs[$];

  ivl_uvm_ovl_window_multi #(
    .NUM_CH  (4),
    .MIN_CKS (2),
    .MAX_CKS (5),
    .ERR_W   (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .start_event (startEvent),
    .test_expr   (testExpr),
    .fire_err    (fireErr),
    .fire_cov    (fireCov),
    .fire_x      (fireX),
    .err_count   (errCount),
    .busy        (busy)
  );

  ivl_uvm_ovl_window_multi #(
    .NUM_CH  (1),
    .MIN_CKS (2),
    .MAX_CKS (5),
    .ERR_W   (2)
  ) dutSat (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .start_event (satStart),
    .test_expr   (satTest),
    .fire_err    (satFireErr),
    .fire_cov    (satFireCov),
    .fire_x      (satFireX),
    .err_count   (satErrCount),
    .busy        (satBusy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic addVec(input logic en, input logic [3:0] start, input logic [3:0] test,
                        input logic [3:0] expErr, input logic [3:0] expCov,
                        input logic [3:0] expBusy, input logic [7:0] expCnt);
    vec_t v;
    v.en = en; v.start = start; v.test = test;
    v.expErr = expErr; v.expCov = expCov; v.expBusy = expBusy; v.expCnt = expCnt;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    enable     = v.en;
    startEvent = v.start;
    testExpr   = v.test;
    tick();
    checkOutput($sformatf("v%0d_fire_err", idx), 32'(fireErr), 32'(v.expErr));
    checkOutput($sformatf("v%0d_fire_cov", idx), 32'(fireCov), 32'(v.expCov));
    checkOutput($sformatf("v%0d_fire_x", idx), 32'(fireX), 32'd0);
    checkOutput($sformatf("v%0d_busy", idx), 32'(busy), 32'(v.expBusy));
    checkOutput($sformatf("v%0d_err_count", idx), 32'(errCount), 32'(v.expCnt));
  endtask

  initial begin
    int split;
    int expSat;
    checkCount = 0;
    errorCount = 0;
    enable     = 1'b0;
    startEvent = '0;
    testExpr   = '0;
    satStart   = '0;
    satTest    = '0;
    reset      = 1'b1;

    // ch0 opens, test_expr at cnt=3 -> coverage pulse one edge later
    addVec(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 8'd0);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 8'd0);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 8'd0);
    addVec(1, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 8'd0);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    // ch1 early at cnt=1
    addVec(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 8'd0);
    addVec(1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    addVec(1, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 8'd1);
    addVec(1, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 8'd1);
    // ch2 start with test high (start wins), restart at cnt=3 ignored, timeout
    addVec(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 8'd1);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 8'd1);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 8'd1);
    addVec(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 8'd1);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 8'd1);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd1);
    addVec(1, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 8'd2);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd2);
    split = vecs.size();
    // ch0 and ch3 time out together after the mid-window reset
    addVec(1, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 8'd0);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 8'd0);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 8'd0);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 8'd0);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 8'd0);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    addVec(1, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 8'd2);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd2);
    // ch1 aborted by enable=0 at cnt=2; no window opens while disabled
    addVec(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 8'd2);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 8'd2);
    addVec(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd2);
    addVec(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd2);
    addVec(1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 8'd2);
    for (int k = 0; k < 6; k++) begin
      addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd2);
    end

    // Reset state
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_fire_err", 32'(fireErr), 32'd0);
    checkOutput("rst_fire_cov", 32'(fireCov), 32'd0);
    checkOutput("rst_fire_x", 32'(fireX), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err_count", 32'(errCount), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b1;
    enable = 1'b1;

    for (int i = 0; i < split; i++) begin
      applyStimulus(i);
    end

    // Asynchronous reset in the middle of a ch1 window (cnt=2)
    startEvent = 4'b0010;
    testExpr   = 4'b0000;
    tick();
    startEvent = 4'b0000;
    tick();
    checkOutput("mid_busy_before_rst", 32'(busy), 32'b0010);
    reset = 1'b0;
    #2;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_err_count", 32'(errCount), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput($sformatf("post_rst%0d_fire_err", k), 32'(fireErr), 32'd0);
      checkOutput($sformatf("post_rst%0d_fire_cov", k), 32'(fireCov), 32'd0);
      checkOutput($sformatf("post_rst%0d_busy", k), 32'(busy), 32'd0);
      checkOutput($sformatf("post_rst%0d_err_count", k), 32'(errCount), 32'd0);
    end

    for (int i = split; i < vecs.size(); i++) begin
      applyStimulus(i);
    end
    startEvent = '0;
    testExpr   = '0;
    enable     = 1'b1;

    // Five back-to-back timeouts into a 2-bit counter
    for (int k = 1; k <= 5; k++) begin
      satStart = 1'b1;
      tick();
      satStart = 1'b0;
      repeat (5) tick();
      checkOutput($sformatf("sat%0d_busy_end", k), 32'(satBusy), 32'd0);
      tick();
      expSat = (k < 3) ? k : 3;
      checkOutput($sformatf("sat%0d_fire_err", k), 32'(satFireErr), 32'd1);
      checkOutput($sformatf("sat%0d_err_count", k), 32'(satErrCount), 32'(expSat));
    end
    tick();
    checkOutput("sat_final_err_count", 32'(satErrCount), 32'd3);

`ifdef IVL_UVM_OVL_XCHECK_EN
    startEvent = 4'b000x;
    tick();
    startEvent = 4'b0000;
    checkOutput("x_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("x_fire_x", 32'(fireX), 32'b0001);
    checkOutput("x_err_count", 32'(errCount), 32'd2);
    tick();
    checkOutput("x_fire_x_clear", 32'(fireX), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
